// File: rtl/queue_tracker.sv
// queue_tracker
//   Keeps per-approach queue counts (main, left, secondary, pedestrian) for the
//   smart traffic light. Sensor pulses add a vehicle/pedestrian to a lane. While
//   a lane holds green, its queue drains at a fixed rate. Counts saturate at
//   2**CNT_W-1 and raise a sticky per-lane saturation flag.
//
//   Ports
//     clk                     system clock, rising edge
//     rst_n                   synchronous active-low reset
//     m_sens/l_sens/s_sens    asynchronous arrival sensors (level)
//     p_sens                  asynchronous pedestrian button (level)
//     m_go/l_go/s_go/p_go     synchronous green/walk per lane
//     clr_sat                 one-cycle pulse clearing sat_flag
//     main_num/left_num/
//     sec_num/p_num           registered queue counts
//     sat_flag                sticky saturation {p,s,l,m}
//
//   Lane index used internally: 0 = main, 1 = left, 2 = secondary, 3 = pedestrian.
module queue_tracker #(
  parameter int CNT_W     = 3,
  parameter int DRAIN_CYC = 8,
  parameter int P_DRAIN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_sens,
  input  logic             l_sens,
  input  logic             s_sens,
  input  logic             p_sens,
  input  logic             m_go,
  input  logic             l_go,
  input  logic             s_go,
  input  logic             p_go,
  input  logic             clr_sat,
  output logic [CNT_W-1:0] main_num,
  output logic [CNT_W-1:0] left_num,
  output logic [CNT_W-1:0] sec_num,
  output logic [CNT_W-1:0] p_num,
  output logic [3:0]       sat_flag
);

  localparam int LANES = 4;
  localparam int PMAX  = (DRAIN_CYC > P_DRAIN) ? DRAIN_CYC : P_DRAIN;
  localparam int PW    = $clog2(PMAX);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]    TERM_V  = PW'(DRAIN_CYC - 1);
  localparam logic [PW-1:0]    TERM_P  = PW'(P_DRAIN - 1);

  logic [LANES-1:0] sens;
  logic [LANES-1:0] go;

  assign sens = {p_sens, s_sens, l_sens, m_sens};
  assign go   = {p_go, s_go, l_go, m_go};

  // Arrival path state
  logic [LANES-1:0] sync1_q, sync1_d;
  logic [LANES-1:0] sync2_q, sync2_d;
  logic [LANES-1:0] hist_q,  hist_d;
  logic [LANES-1:0] armed_q, armed_d;
  logic [LANES-1:0] arrive_q, arrive_d;
  logic [1:0]       warm_q,  warm_d;

  // Drain path state
  logic [PW-1:0]    presc_q [LANES];
  logic [PW-1:0]    presc_d [LANES];
  logic [LANES-1:0] depart;

  // Counts and flags
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [CNT_W-1:0] cnt_d [LANES];
  logic [LANES-1:0] sat_q, sat_d;
  logic [LANES-1:0] sat_set;

  // ------------------------------------------------------------------
  // Arrival: 2-flop synchronizer, rising-edge detect, registered event.
  // Sensor sampled high at edge k -> arrive_q high after edge k+2 ->
  // count updated at edge k+3.
  //
  // The synchronizer flops come out of reset at 0, which would look like a
  // genuine low sample and turn a sensor held high through reset into a false
  // arrival. warm_q delays arming until sync2_q carries real post-reset data;
  // a lane arms only once it has actually seen its sensor low.
  // ------------------------------------------------------------------
  always_comb begin
    sync1_d  = sens;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    warm_d   = {warm_q[0], 1'b1};
    armed_d  = armed_q | ({LANES{warm_q[1]}} & ~sync2_q);
    arrive_d = sync2_q & ~hist_q & armed_q;
  end

  // ------------------------------------------------------------------
  // Drain prescaler: runs while go & count>0, otherwise held at 0.
  // depart fires on the cycle the prescaler sits at its terminal value,
  // so the first departure lands DRAIN_CYC edges after go rises.
  // ------------------------------------------------------------------
  always_comb begin
    depart = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      presc_d[i] = '0;
      if (go[i] && (cnt_q[i] != '0)) begin
        if (presc_q[i] == ((i == 3) ? TERM_P : TERM_V)) begin
          depart[i]  = 1'b1;
          presc_d[i] = '0;
        end else begin
          presc_d[i] = presc_q[i] + PW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Count update and saturation flags.
  // ------------------------------------------------------------------
  always_comb begin
    sat_set = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({arrive_q[i], depart[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) begin
            sat_set[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        2'b01: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    // A saturation in the same cycle as clr_sat survives the clear.
    sat_d = (clr_sat ? '0 : sat_q) | sat_set;
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      armed_q  <= '0;
      arrive_q <= '0;
      warm_q   <= '0;
      sat_q    <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        presc_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      armed_q  <= armed_d;
      arrive_q <= arrive_d;
      warm_q   <= warm_d;
      sat_q    <= sat_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        presc_q[i] <= presc_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign main_num = cnt_q[0];
  assign left_num = cnt_q[1];
  assign sec_num  = cnt_q[2];
  assign p_num    = cnt_q[3];
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_queue_tracker.sv
module tb_queue_tracker;

  logic       clk;
  logic       rst_n;
  logic [3:0] sens;
  logic [3:0] go;
  logic       clr_sat;
  logic [2:0] main_num, left_num, sec_num, p_num;
  logic [3:0] sat_flag;

  queue_tracker #(
    .CNT_W    (3),
    .DRAIN_CYC(8),
    .P_DRAIN  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_sens  (sens[0]),
    .l_sens  (sens[1]),
    .s_sens  (sens[2]),
    .p_sens  (sens[3]),
    .m_go    (go[0]),
    .l_go    (go[1]),
    .s_go    (go[2]),
    .p_go    (go[3]),
    .clr_sat (clr_sat),
    .main_num(main_num),
    .left_num(left_num),
    .sec_num (sec_num),
    .p_num   (p_num),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         sel;
    logic [3:0] exp;
  } sb_t;

  sb_t        sb[$];
  int         checks;
  int         errors;
  int         cyc;
  int         ecnt[4];
  logic [3:0] esat;

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      0:       return 4'(main_num);
      1:       return 4'(left_num);
      2:       return 4'(sec_num);
      3:       return 4'(p_num);
      default: return sat_flag;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "main_num";
      1:       return "left_num";
      2:       return "sec_num";
      3:       return "p_num";
      default: return "sat_flag";
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int due, input int sel, input logic [3:0] exp);
    sb_t e;
    e.due = due;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_all(input int due);
    for (int i = 0; i < 4; i++) push(due, i, 4'(ecnt[i]));
    push(due, 4, esat);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) check({tag, "_", sel_name(i)}, observe(i), 4'(ecnt[i]));
    check({tag, "_sat_flag"}, sat_flag, esat);
  endtask

  // Pop and compare every scoreboard entry due at the current edge.
  task automatic sb_check();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check({"sb_", sel_name(sb[i].sel)}, observe(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    sb_check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle sensor pulse with no drain active on that lane; the count
  // must still be old 3 edges later and updated 4 edges after driving.
  task automatic pulse(input int lane);
    sens[lane] = 1'b1;
    push(cyc + 3, lane, 4'(ecnt[lane]));
    push(cyc + 3, 4, esat);
    if (ecnt[lane] < 7) ecnt[lane]++;
    else esat[lane] = 1'b1;
    push(cyc + 4, lane, 4'(ecnt[lane]));
    push(cyc + 4, 4, esat);
    tick();
    sens[lane] = 1'b0;
    run(3);
  endtask

  task automatic pulse_clr();
    clr_sat = 1'b1;
    esat    = '0;
    push(cyc + 1, 4, esat);
    tick();
    clr_sat = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d observed timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    esat    = '0;
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    rst_n   = 1'b0;
    sens    = '1;
    go      = '1;
    clr_sat = 1'b0;

    // Reset with sensors and go high
    run(3);
    check_all("reset");
    rst_n = 1'b1;
    go    = '0;
    run(8);
    check_all("held_high");
    sens = '0;
    run(4);
    check_all("held_low");

    // Arrival latency on main
    for (int i = 0; i < 5; i++) pulse(0);
    check_all("arrival");

    // Saturation on left
    for (int i = 0; i < 10; i++) pulse(1);
    check_all("saturate");
    pulse_clr();
    pulse(1);
    check_all("resaturate");
    pulse_clr();
    // Saturating arrival lands on the same edge as clr_sat
    c = cyc;
    sens[1] = 1'b1;
    tick();
    sens[1] = 1'b0;
    run(2);
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    check("set_wins_cycle", 4'(cyc - c), 4'd4);
    esat[1] = 1'b1;
    check("set_wins", sat_flag, esat);
    pulse_clr();

    // Drain on secondary
    for (int i = 0; i < 3; i++) pulse(2);
    c = cyc;
    go[2] = 1'b1;
    push(c + 7, 2, 4'd3);
    push(c + 8, 2, 4'd2);
    push(c + 15, 2, 4'd2);
    push(c + 16, 2, 4'd1);
    push(c + 23, 2, 4'd1);
    push(c + 24, 2, 4'd0);
    push(c + 30, 2, 4'd0);
    run(30);
    go[2]   = 1'b0;
    ecnt[2] = 0;
    check_all("drain");

    // Plain reset between sections
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    esat = '0;
    check_all("reset2");
    tick();

    // go interruption on main
    for (int i = 0; i < 2; i++) pulse(0);
    c = cyc;
    go[0] = 1'b1;
    run(5);
    go[0] = 1'b0;
    tick();
    check("interrupt_hold", 4'(main_num), 4'd2);
    go[0] = 1'b1;
    push(c + 13, 0, 4'd2);
    push(c + 14, 0, 4'd1);
    run(8);
    go[0]   = 1'b0;
    ecnt[0] = 1;
    run(6);
    check_all("interrupt");

    // Pedestrian arrival and departure on the same edge at MAX
    for (int i = 0; i < 7; i++) pulse(3);
    check_all("p_full");
    c = cyc;
    go[3]   = 1'b1;
    sens[3] = 1'b1;
    push(c + 3, 3, 4'd7);
    push(c + 4, 3, 4'd7);
    push(c + 4, 4, 4'd0);
    push(c + 7, 3, 4'd7);
    push(c + 8, 3, 4'd6);
    tick();
    sens[3] = 1'b0;
    run(8);
    ecnt[3] = 6;
    check_all("simul");

    // Reset in the middle of a drain
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    esat = '0;
    push_all(cyc + 1);
    tick();
    rst_n = 1'b1;
    go    = '0;
    run(2);

    check("sb_empty", 4'(sb.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
